// File: rtl/rectangle_sbox_layer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rectangle_sbox_layer_ctrl_pkg
// Shared definitions for the masked RECTANGLE S-box layer sequencer:
//   - state_t       : sequencer state encoding
//   - NIB_DEF       : nibbles per 64-bit state
//   - RND_W_DEF     : fresh-randomness bits consumed per nibble
//   - SBOX_LAT_DEF  : latency of the shared masked S-box pipeline
//   - RECT_SBOX     : unmasked RECTANGLE S-box table (nibble i holds S(i)),
//                     used by reference models
// -----------------------------------------------------------------------------
package rectangle_sbox_layer_ctrl_pkg;

    localparam int NIB_DEF      = 16;
    localparam int RND_W_DEF    = 8;
    localparam int SBOX_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // S(0)..S(15) = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2 packed LSB-first.
    localparam logic [63:0] RECT_SBOX = 64'h24F8_D30B_97E1_AC56;

    function automatic logic [3:0] rect_sbox(input logic [3:0] x);
        return RECT_SBOX[4*x +: 4];
    endfunction

endpackage

// File: rtl/rectangle_sbox_layer_ctrl_sbox_valid_tracker.sv
// -----------------------------------------------------------------------------
// sbox_valid_tracker
// DEPTH-deep shift register mirroring the S-box pipeline: a 1 marks a real
// nibble, a 0 a bubble. The tail lines up with the S-box output of the same
// slot, so it directly qualifies result capture.
// Ports:
//   clk, rst (async, active high)
//   clr   : synchronous clear (new pass)
//   shift : advance one stage
//   din   : valid bit entering the pipeline this cycle
//   tail  : valid bit of the slot currently leaving the S-box
// -----------------------------------------------------------------------------
module sbox_valid_tracker #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (shift) begin
            // Shift-and-or form stays legal for DEPTH == 1.
            sr <= (sr << 1) | DEPTH'(din);
        end
    end

    assign tail = sr[DEPTH-1];

endmodule

// File: rtl/rectangle_sbox_layer_ctrl.sv
// -----------------------------------------------------------------------------
// rectangle_sbox_layer_ctrl
// Streams a 3-share masked 64-bit RECTANGLE state through one shared 4-bit
// masked S-box, one nibble per cycle, pairing each nibble with RND_W fresh
// random bits. Randomness stalls become pipeline bubbles, tracked so only
// real nibbles are captured back into the output shares.
// Ports:
//   clk, rst (async, active high)
//   start                    : begin a pass (IDLE only)
//   in_share1..3             : input shares, latched on accepted start
//   rnd, rnd_valid/rnd_ready : fresh randomness handshake
//   sbox_in1..3, sbox_r      : nibble shares + randomness to the S-box
//   sbox_out1..3             : S-box output shares (SBOX_LAT cycles later)
//   busy, done               : pass in progress / one-cycle completion pulse
//   out_share1..3            : result shares
// Build option: RECT_SBOX_CTRL_ZEROIZE_EN clears the latched input shares after
// the last issue and clears out_share* on an accepted start.
// Share paths are kept strictly separate; no two shares are ever combined.
// -----------------------------------------------------------------------------
module rectangle_sbox_layer_ctrl
    import rectangle_sbox_layer_ctrl_pkg::*;
#(
    parameter int NIB      = NIB_DEF,
    parameter int SBOX_LAT = SBOX_LAT_DEF,
    parameter int RND_W    = RND_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIB-1:0]     in_share1,
    input  logic [4*NIB-1:0]     in_share2,
    input  logic [4*NIB-1:0]     in_share3,
    input  logic [RND_W-1:0]     rnd,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [3:0]           sbox_in1,
    output logic [3:0]           sbox_in2,
    output logic [3:0]           sbox_in3,
    output logic [RND_W-1:0]     sbox_r,
    input  logic [3:0]           sbox_out1,
    input  logic [3:0]           sbox_out2,
    input  logic [3:0]           sbox_out3,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIB-1:0]     out_share1,
    output logic [4*NIB-1:0]     out_share2,
    output logic [4*NIB-1:0]     out_share3
);

    localparam int CW = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t          state, state_next;
    logic [4*NIB-1:0] in_reg1, in_reg2, in_reg3;
    logic [CW-1:0]   iss, cap;
    logic            start_acc, issue, last_issue, cap_en, last_cap, tail;

    assign start_acc  = (state == ST_IDLE) && start;
    // Randomness is consumed only together with an issued nibble.
    assign issue      = (state == ST_FEED) && rnd_valid;
    assign last_issue = issue && (iss == LAST);
    assign busy       = (state == ST_FEED) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign cap_en     = busy && tail;
    assign last_cap   = cap_en && (cap == LAST);

    assign rnd_ready  = issue;
    assign sbox_in1   = issue ? in_reg1[4*iss +: 4] : 4'h0;
    assign sbox_in2   = issue ? in_reg2[4*iss +: 4] : 4'h0;
    assign sbox_in3   = issue ? in_reg3[4*iss +: 4] : 4'h0;
    assign sbox_r     = issue ? rnd : '0;

    sbox_valid_tracker #(.DEPTH(SBOX_LAT)) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .shift (busy),
        .din   (issue),
        .tail  (tail)
    );

    // NOTE: next-state defaults to the current state before the case, so no
    // path leaves state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)      state_next = ST_FEED;
            ST_FEED:  if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (last_cap)   state_next = ST_DONE;
            ST_DONE:                  state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            iss     <= '0;
            cap     <= '0;
            in_reg1 <= '0;
            in_reg2 <= '0;
            in_reg3 <= '0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                in_reg1 <= in_share1;
                in_reg2 <= in_share2;
                in_reg3 <= in_share3;
                iss     <= '0;
                cap     <= '0;
            end else begin
                if (issue)  iss <= iss + CW'(1);
                if (cap_en) cap <= cap + CW'(1);
`ifdef RECT_SBOX_CTRL_ZEROIZE_EN
                // Input shares are dead once the last nibble has left.
                if (last_issue) begin
                    in_reg1 <= '0;
                    in_reg2 <= '0;
                    in_reg3 <= '0;
                end
`endif
            end
        end
    end

    // Result shares only change at capture (or zeroize on start), so a
    // partially updated state is visible while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_share1 <= '0;
            out_share2 <= '0;
            out_share3 <= '0;
        end else begin
`ifdef RECT_SBOX_CTRL_ZEROIZE_EN
            if (start_acc) begin
                out_share1 <= '0;
                out_share2 <= '0;
                out_share3 <= '0;
            end
`endif
            if (cap_en) begin
                out_share1[4*cap +: 4] <= sbox_out1;
                out_share2[4*cap +: 4] <= sbox_out2;
                out_share3[4*cap +: 4] <= sbox_out3;
            end
        end
    end

endmodule
